// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter
// Description : Integer ALU with single-cycle logic/arith/shift/compare ops
//               and iterative radix-2 multiply/divide (WIDTH cycles each).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_err
);

    localparam int c_SHW = $clog2(WIDTH);

    localparam logic [4:0] c_OP_ADD    = 5'b00000;
    localparam logic [4:0] c_OP_SUB    = 5'b01000;
    localparam logic [4:0] c_OP_AND    = 5'b00111;
    localparam logic [4:0] c_OP_OR     = 5'b00110;
    localparam logic [4:0] c_OP_XOR    = 5'b00100;
    localparam logic [4:0] c_OP_SRL    = 5'b00101;
    localparam logic [4:0] c_OP_SLL    = 5'b00001;
    localparam logic [4:0] c_OP_SRA    = 5'b01101;
    localparam logic [4:0] c_OP_SLT    = 5'b00010;
    localparam logic [4:0] c_OP_SLTU   = 5'b00011;
    localparam logic [4:0] c_OP_MULH   = 5'b10001;
    localparam logic [4:0] c_OP_MULHSU = 5'b10010;
    localparam logic [4:0] c_OP_DIV    = 5'b10100;
    localparam logic [4:0] c_OP_REM    = 5'b10110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_long_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg_hi;
    logic               r_neg_lo;
    logic [c_SHW-1:0]   r_cnt;

    logic [c_SHW-1:0]   w_sh;
    logic [WIDTH-1:0]   w_fast_res;
    logic               w_fast_err;
    logic               w_is_long;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_dsh;
    logic               w_dge;
    logic [WIDTH-1:0]   w_dsub;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic [WIDTH-1:0]   w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_long_res;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    assign w_sh = in1[c_SHW-1:0];

    always_comb begin
        w_fast_res = '0;
        w_fast_err = 1'b0;
        case (op)
            c_OP_ADD:  w_fast_res = in0 + in1;
            c_OP_SUB:  w_fast_res = in0 - in1;
            c_OP_AND:  w_fast_res = in0 & in1;
            c_OP_OR:   w_fast_res = in0 | in1;
            c_OP_XOR:  w_fast_res = in0 ^ in1;
            c_OP_SRL:  w_fast_res = in0 >> w_sh;
            c_OP_SLL:  w_fast_res = in0 << w_sh;
            c_OP_SRA:  w_fast_res = $signed(in0) >>> w_sh;
            c_OP_SLT:  w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
            c_OP_SLTU: w_fast_res = {{(WIDTH-1){1'b0}}, (in0 < in1)};
            default:   w_fast_err = 1'b1;
        endcase
    end

    // Iterative ops run on magnitudes; signs are reapplied on the final step.
    assign w_is_long  = op[4] & ~op[3];
    assign w_a_signed = (op == c_OP_MULH) | (op == c_OP_MULHSU) | (op == c_OP_DIV) | (op == c_OP_REM);
    assign w_b_signed = (op == c_OP_MULH) | (op == c_OP_DIV) | (op == c_OP_REM);
    assign w_a_neg    = w_a_signed & in0[WIDTH-1];
    assign w_b_neg    = w_b_signed & in1[WIDTH-1];
    assign w_a_mag    = w_a_neg ? ('0 - in0) : in0;
    assign w_b_mag    = w_b_neg ? ('0 - in1) : in1;

    // Shift-add multiply step: {r_hi, r_lo} holds partial product and multiplier.
    assign w_sum    = {1'b0, r_hi} + {1'b0, r_b};
    assign w_mul_hi = r_lo[0] ? w_sum[WIDTH:1] : {1'b0, r_hi[WIDTH-1:1]};
    assign w_mul_lo = {(r_lo[0] ? w_sum[0] : r_hi[0]), r_lo[WIDTH-1:1]};

    // Restoring divide step: r_hi is the partial remainder, r_lo the quotient.
    assign w_dsh    = {r_hi, r_lo[WIDTH-1]};
    assign w_dge    = (w_dsh >= {1'b0, r_b});
    assign w_dsub   = w_dsh[WIDTH-1:0] - r_b;
    assign w_div_hi = w_dge ? w_dsub : w_dsh[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_dge};

    assign w_hi_n = r_long_op[2] ? w_div_hi : w_mul_hi;
    assign w_lo_n = r_long_op[2] ? w_div_lo : w_mul_lo;

    assign w_prod_s = r_neg_lo ? ('0 - {w_hi_n, w_lo_n}) : {w_hi_n, w_lo_n};
    assign w_quo    = r_neg_lo ? ('0 - w_lo_n) : w_lo_n;
    assign w_rem    = r_neg_hi ? ('0 - w_hi_n) : w_hi_n;

    always_comb begin
        w_long_res = '0;
        case (r_long_op)
            3'b000:         w_long_res = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         w_long_res = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: w_long_res = w_quo;
            default:        w_long_res = w_rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_long_op <= 3'b000;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_neg_hi  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_cnt     <= '0;
            out       <= '0;
            out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_is_long) begin
                            r_long_op <= op[2:0];
                            r_hi      <= '0;
                            r_lo      <= w_a_mag;
                            r_b       <= w_b_mag;
                            // A zero divisor keeps the all-ones quotient unsigned.
                            r_neg_lo  <= op[2] ? ((w_a_neg ^ w_b_neg) & (in1 != '0))
                                               : (w_a_neg ^ w_b_neg);
                            r_neg_hi  <= w_a_neg;
                            r_cnt     <= '0;
                            r_state   <= S_BUSY;
                        end else begin
                            out     <= w_fast_res;
                            out_err <= w_fast_err;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_SHW'(WIDTH - 1)) begin
                        out     <= w_long_res;
                        out_err <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_iter
// Description : Directed table-driven bench for alu_iter at WIDTH 8/32/64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [4:0]  op;
    logic [63:0] in0;
    logic [63:0] in1;
    int          sel;

    logic        iv8, iv32, iv64;
    logic        ir8, ir32, ir64;
    logic        ov8, ov32, ov64;
    logic        oe8, oe32, oe64;
    logic [7:0]  o8;
    logic [31:0] o32;
    logic [63:0] o64;

    logic [63:0] m_out;
    logic        m_valid, m_ready, m_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          w;
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign iv8  = in_valid && (sel == 8);
    assign iv32 = in_valid && (sel == 32);
    assign iv64 = in_valid && (sel == 64);

    alu_iter #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid(iv8), .in_ready(ir8), .op(op),
        .in0(in0[7:0]), .in1(in1[7:0]), .out_valid(ov8), .out_ready(out_ready),
        .out(o8), .out_err(oe8)
    );

    alu_iter #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .in_valid(iv32), .in_ready(ir32), .op(op),
        .in0(in0[31:0]), .in1(in1[31:0]), .out_valid(ov32), .out_ready(out_ready),
        .out(o32), .out_err(oe32)
    );

    alu_iter #(.WIDTH(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .in_valid(iv64), .in_ready(ir64), .op(op),
        .in0(in0), .in1(in1), .out_valid(ov64), .out_ready(out_ready),
        .out(o64), .out_err(oe64)
    );

    always_comb begin
        m_out = '0; m_valid = 1'b0; m_ready = 1'b0; m_err = 1'b0;
        case (sel)
            8:  begin m_out = {56'b0, o8};  m_valid = ov8;  m_ready = ir8;  m_err = oe8;  end
            64: begin m_out = o64;          m_valid = ov64; m_ready = ir64; m_err = oe64; end
            default: begin m_out = {32'b0, o32}; m_valid = ov32; m_ready = ir32; m_err = oe32; end
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input int w, input logic [4:0] o, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] e, input logic er,
                                input string n);
        vec_t v;
        v.w = w; v.op = o; v.a = a; v.b = b; v.exp = e; v.err = er; v.name = n;
        vecs.push_back(v);
    endfunction

    // Issue one request, wait (bounded) for the result, check value, flag and latency.
    task automatic run_op(input vec_t v);
        int lat;
        int exp_lat;
        sel = v.w; op = v.op; in0 = v.a; in1 = v.b; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!m_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = (v.op[4] && !v.op[3]) ? v.w : 0;
        chk({v.name, "_out"}, m_out, v.exp);
        chk({v.name, "_err"}, 64'(m_err), 64'(v.err));
        chk({v.name, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
        chk({v.name, "_idle"}, 64'(m_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vec_t v;
        logic [63:0] hold;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; in0 = '0; in1 = '0; sel = 32;

        add(32, 5'b00000, 64'hFFFFFFFF, 64'h1,        64'h0,        1'b0, "add_wrap");
        add(32, 5'b01000, 64'h3,        64'h5,        64'hFFFFFFFE, 1'b0, "sub_wrap");
        add(32, 5'b00111, 64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 1'b0, "and");
        add(32, 5'b00110, 64'hF0F0F0F0, 64'hFF00FF00, 64'hFFF0FFF0, 1'b0, "or");
        add(32, 5'b00100, 64'hF0F0F0F0, 64'hFF00FF00, 64'h0FF00FF0, 1'b0, "xor");
        add(32, 5'b01101, 64'h80000000, 64'h21,       64'hC0000000, 1'b0, "sra");
        add(32, 5'b00101, 64'h80000000, 64'h24,       64'h08000000, 1'b0, "srl");
        add(32, 5'b00001, 64'h1,        64'h1F,       64'h80000000, 1'b0, "sll");
        add(32, 5'b00010, 64'hFFFFFFFF, 64'h1,        64'h1,        1'b0, "slt");
        add(32, 5'b00011, 64'hFFFFFFFF, 64'h1,        64'h0,        1'b0, "sltu");
        add(32, 5'b11111, 64'h12345678, 64'h9,        64'h0,        1'b1, "bad_11111");
        add(32, 5'b01001, 64'h12345678, 64'h9,        64'h0,        1'b1, "bad_01001");
        add(32, 5'b10000, 64'h7,        64'h6,        64'h2A,       1'b0, "mul");
        add(32, 5'b10000, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1,        1'b0, "mul_low");
        add(32, 5'b10001, 64'h80000000, 64'h80000000, 64'h40000000, 1'b0, "mulh");
        add(32, 5'b10011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 1'b0, "mulhu");
        add(32, 5'b10010, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFF, 1'b0, "mulhsu");
        add(32, 5'b10100, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 1'b0, "div_neg");
        add(32, 5'b10110, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 1'b0, "rem_neg");
        add(32, 5'b10100, 64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, 1'b0, "div_negb");
        add(32, 5'b10110, 64'h7,        64'hFFFFFFFE, 64'h1,        1'b0, "rem_negb");
        add(32, 5'b10101, 64'h5,        64'h0,        64'hFFFFFFFF, 1'b0, "divu_zero");
        add(32, 5'b10111, 64'h5,        64'h0,        64'h5,        1'b0, "remu_zero");
        add(32, 5'b10100, 64'hFFFFFFF9, 64'h0,        64'hFFFFFFFF, 1'b0, "div_zero");
        add(32, 5'b10110, 64'hFFFFFFF9, 64'h0,        64'hFFFFFFF9, 1'b0, "rem_zero");
        add(32, 5'b10100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1'b0, "div_ovf");
        add(32, 5'b10110, 64'h80000000, 64'hFFFFFFFF, 64'h0,        1'b0, "rem_ovf");
        add(32, 5'b10101, 64'd100,      64'd7,        64'd14,       1'b0, "divu");
        add(32, 5'b10111, 64'd100,      64'd7,        64'd2,        1'b0, "remu");
        add(8,  5'b00000, 64'hFF, 64'h1,  64'h0,  1'b0, "w8_add_wrap");
        add(8,  5'b01101, 64'h80, 64'h09, 64'hC0, 1'b0, "w8_sra");
        add(8,  5'b00010, 64'hFF, 64'h1,  64'h1,  1'b0, "w8_slt");
        add(8,  5'b00011, 64'hFF, 64'h1,  64'h0,  1'b0, "w8_sltu");
        add(8,  5'b11111, 64'h12, 64'h3,  64'h0,  1'b1, "w8_bad");
        add(8,  5'b10001, 64'h80, 64'h80, 64'h40, 1'b0, "w8_mulh");
        add(8,  5'b10011, 64'hFF, 64'hFF, 64'hFE, 1'b0, "w8_mulhu");
        add(8,  5'b10100, 64'hF9, 64'h2,  64'hFD, 1'b0, "w8_div");
        add(8,  5'b10110, 64'hF9, 64'h2,  64'hFF, 1'b0, "w8_rem");
        add(8,  5'b10101, 64'h5,  64'h0,  64'hFF, 1'b0, "w8_divu_zero");
        add(8,  5'b10111, 64'h5,  64'h0,  64'h5,  1'b0, "w8_remu_zero");
        add(8,  5'b10100, 64'h80, 64'hFF, 64'h80, 1'b0, "w8_div_ovf");
        add(64, 5'b00000, 64'hFFFFFFFFFFFFFFFF, 64'h1,  64'h0,                1'b0, "w64_add_wrap");
        add(64, 5'b01101, 64'h8000000000000000, 64'h41, 64'hC000000000000000, 1'b0, "w64_sra");
        add(64, 5'b00010, 64'hFFFFFFFFFFFFFFFF, 64'h1,  64'h1,                1'b0, "w64_slt");
        add(64, 5'b10001, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 1'b0, "w64_mulh");
        add(64, 5'b10011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1'b0, "w64_mulhu");
        add(64, 5'b10100, 64'hFFFFFFFFFFFFFFF9, 64'h2,  64'hFFFFFFFFFFFFFFFD, 1'b0, "w64_div");
        add(64, 5'b10110, 64'hFFFFFFFFFFFFFFF9, 64'h2,  64'hFFFFFFFFFFFFFFFF, 1'b0, "w64_rem");
        add(64, 5'b10101, 64'h5, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, "w64_divu_zero");
        add(64, 5'b10100, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1'b0, "w64_div_ovf");

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out",       {32'b0, o32}, 64'h0);
        chk("rst_err",       64'(oe32), 64'h0);
        chk("rst_ready",     64'({ir8, ir32, ir64}), 64'h7);
        chk("rst_valid",     64'({ov8, ov32, ov64}), 64'h0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Backpressure: result must hold and inputs must be ignored while DONE.
        sel = 32; out_ready = 1'b0;
        op = 5'b00100; in0 = 64'hA5A5A5A5; in1 = 64'h0F0F0F0F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_first_valid", 64'(m_valid), 64'd1);
        chk("bp_first_out", m_out, 64'hAAAAAAAA);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; op = 5'b00000; in0 = 64'(i); in1 = 64'd1;
            @(posedge clk); #1;
            chk("bp_hold_out", m_out, 64'hAAAAAAAA);
            chk("bp_hold_ready", 64'(m_ready), 64'd0);
            chk("bp_hold_valid", 64'(m_valid), 64'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 64'(m_ready), 64'd1);
        chk("bp_release_valid", 64'(m_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_ghost", 64'(m_valid), 64'd0);

        // Reset in the fifth BUSY cycle discards the multiply.
        sel = 32; op = 5'b10000; in0 = 64'd3; in1 = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_before_rst", 64'(m_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("busy_rst_ready", 64'(m_ready), 64'd1);
        chk("busy_rst_valid", 64'(m_valid), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (m_valid) seen = 1;
        end
        chk("busy_rst_no_result", 64'(seen), 64'd0);
        v.w = 32; v.op = 5'b00000; v.a = 64'd2; v.b = 64'd3; v.exp = 64'd5; v.err = 1'b0;
        v.name = "post_rst_add";
        run_op(v);

        // Reset while DONE clears result, error flag and out_valid.
        out_ready = 1'b0; op = 5'b11111; in0 = 64'h55; in1 = 64'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        hold = 64'(m_err);
        chk("done_err_set", hold, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("done_rst_valid", 64'(m_valid), 64'd0);
        chk("done_rst_err", 64'(m_err), 64'd0);
        chk("done_rst_ready", 64'(m_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_rst_no_result", 64'(m_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; legal values 8..64, even; SHW = clog2(WIDTH).
REQ-002 Port: clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  request present.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: op  input  5  operation code (REQ-010).
REQ-007 Port: in0, in1  input  WIDTH each  operands A and B.
REQ-008 Port: out_valid  output  1  result present; out_ready  input  1  consumer accepts result.
REQ-009 Port: out  output  WIDTH  result; out_err  output  1  unsupported op code flag.

Function
REQ-010 Op codes SHALL be: 00000 ADD, 01000 SUB, 00111 AND, 00110 OR, 00100 XOR, 00101 SRL, 00001 SLL, 01101 SRA, 00010 SLT, 00011 SLTU; 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-011 Request SHALL be accepted in a cycle where in_valid & in_ready; op, in0, in1 captured that cycle; inputs ignored otherwise.
REQ-012 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 IDLE: accept of op[4]=0 or unsupported code -> DONE; accept of op[4]=1 -> BUSY; no accept -> stay.
REQ-014 BUSY SHALL last exactly WIDTH cycles (one radix-2 step per cycle), then -> DONE, independent of operand values.
REQ-015 DONE: out, out_err held stable; out_valid & out_ready -> IDLE; otherwise stay.
REQ-016 Latency: request accepted at edge t -> out_valid at t+1 (single-cycle ops) or t+WIDTH+1 (mul/div ops).
REQ-017 ADD/SUB/logic SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-018 Shifts SHALL use in1[SHW-1:0] only; SRA fills with A[WIDTH-1]; SRL/SLL fill with 0.
REQ-019 SLT compares signed, SLTU unsigned; result 1 or 0 zero-extended to WIDTH.
REQ-020 MUL returns low WIDTH bits of product; MULH signed x signed, MULHSU signed A x unsigned B, MULHU unsigned x unsigned return high WIDTH bits of 2*WIDTH product.
REQ-021 DIV/REM signed truncate toward zero, remainder takes sign of dividend; DIVU/REMU unsigned.
REQ-022 Divide by zero: DIV/DIVU -> all ones; REM/REMU -> in0; out_err=0.
REQ-023 Signed overflow (A = most negative, B = all ones): DIV -> A; REM -> 0.
REQ-024 Unsupported op code: out = 0, out_err = 1; out_err = 0 for every supported code.
REQ-025 No new request SHALL be accepted in BUSY or DONE; back-to-back throughput therefore >= 2 cycles/op.

Reset
REQ-026 rst_i high at an edge SHALL force state IDLE, out = 0, out_err = 0, out_valid = 0, in_ready = 1 next cycle; priority over all other events.
REQ-027 Reset during BUSY or DONE SHALL discard the in-flight operation; no result SHALL be presented afterwards.

Verification
REQ-028 WIDTH=32: ADD 0xFFFFFFFF + 1 -> out 0x00000000 at t+1, out_err 0; SRA 0x80000000 by in1=0x21 -> 0xC0000000.
REQ-029 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; op 11111 -> out 0, out_err 1.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000, out_valid exactly at t+33; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-032 Backpressure: out_ready held 0 for 10 cycles in DONE -> out stable, in_ready 0, in_valid pulses ignored; then out_ready 1 -> IDLE next cycle.
REQ-033 rst_i asserted at BUSY cycle 5 -> next cycle in_ready 1, out_valid 0; new ADD 2+3 then returns 5 at t+1; also rerun REQ-028..031 subset at WIDTH=8 and WIDTH=64.
